mem_bus_ctrl: RTL

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-port CPU-to-memory bus controller with tristate data bus and transaction counters
module mem_bus_ctrl #(
  parameter int MEM_DEPTH = 512,
  parameter int WR_CYCLES = 1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        err,
  output logic [15:0] mem_address,
  output logic        mem_write,
  inout  wire  [15:0] mem_data,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, RSP, WR_DRIVE, WR_REL} state_t;
  state_t      r_state;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic        r_err;
  logic        r_mem_write;
  logic [15:0] r_mem_address;
  logic [15:0] r_wdata;
  logic [3:0]  r_cnt;
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;
  logic        w_in_range;
  assign w_in_range  = 32'(req_addr) < 32'(MEM_DEPTH);
  assign req_ready   = r_state == IDLE;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign err         = r_err;
  assign mem_address = r_mem_address;
  assign mem_write   = r_mem_write;
  assign rd_count    = r_rd_count;
  assign wr_count    = r_wr_count;
  assign mem_data    = r_mem_write ? r_wdata : 16'hzzzz;
  // Transaction FSM; the bus is driven only while the write strobe is high
  always_ff @(posedge clock or negedge nReset)
    if (!nReset) begin
      r_state       <= IDLE;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_err         <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rd_count    <= '0;
      r_wr_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_err <= req_valid && !w_in_range;
          if (req_valid) begin
            if (!w_in_range) begin
              if (!req_write) begin
                r_state     <= RSP;
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= '0;
              end
            end else if (req_write) begin
              r_state       <= WR_DRIVE;
              r_mem_write   <= 1'b1;
              r_mem_address <= req_addr;
              r_wdata       <= req_wdata;
              r_cnt         <= 4'(WR_CYCLES - 1);
            end else begin
              r_state       <= RD_ADDR;
              r_mem_address <= req_addr;
            end
          end
        end
        RD_ADDR: r_state <= RD_CAP;
        RD_CAP: begin
          r_rsp_rdata <= mem_data;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_err       <= 1'b0;
          r_rd_count  <= r_rd_count + 16'd1;
        end
        WR_DRIVE: if (r_cnt == 4'd0) begin
          r_state     <= WR_REL;
          r_mem_write <= 1'b0;
        end else r_cnt <= r_cnt - 4'd1;
        WR_REL: begin
          r_state    <= IDLE;
          r_wr_count <= r_wr_count + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
